// File: rtl/jtag_test_ctrl_bank.sv
// JTAG test-data-register bank: length-checked TCR, EXTEST shift/update pair,
// and a DEBUG status register that counts malformed scans.
module jtag_test_ctrl_bank #(
  parameter int NUM_CH     = 4,
  parameter int CONRLEN    = 32,
  parameter int TRCAL_SIZE = 32
) (
  input  logic                  tclk,
  input  logic                  test_logic_reset_ni,
  input  logic                  shift_dr_i,
  input  logic                  pause_dr_i,
  input  logic                  update_dr_i,
  input  logic                  capture_dr_i,
  input  logic                  sample_preload_sel,
  input  logic                  extest_sel,
  input  logic                  debug_sel,
  input  logic                  chiptdi,
  input  logic [NUM_CH-1:0]     ch_in_a,
  input  logic [NUM_CH-1:0]     ch_in_b,
  output logic [NUM_CH-1:0]     ch_out,
  output logic                  debug_tdi_o,
  output logic                  bs_chain_tdi_o,
  output logic [CONRLEN-1:0]    tcr_out,
  input  logic [TRCAL_SIZE-1:0] trcal_tr_in,
  output logic [TRCAL_SIZE-1:0] trcal_tr_out,
  output logic                  len_err_o
);

  localparam int CNT_W  = 8;
  localparam int ERR_W  = 7;
  localparam int STAT_W = 16;

  localparam logic [CNT_W-1:0] TCR_LEN = CNT_W'(CONRLEN);
  localparam logic [CNT_W-1:0] TRC_LEN = CNT_W'(TRCAL_SIZE);
  localparam logic [CNT_W-1:0] DBG_LEN = CNT_W'(STAT_W);

  logic [CONRLEN-1:0]    r_tcr;
  logic [CONRLEN-1:0]    r_tcr_shift;
  logic [TRCAL_SIZE-1:0] r_trcal_shift;
  logic [TRCAL_SIZE-1:0] r_trcal_out;
  logic [STAT_W-1:0]     r_dbg_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_last_cnt;
  logic [ERR_W-1:0]      r_err_cnt;
  logic                  r_len_err;
  logic                  r_bs;

  logic              w_sel_ext, w_sel_sp, w_sel_dbg, w_sel_any;
  logic              w_cnt_nz, w_upd_nz;
  logic              w_tcr_wr, w_trc_wr, w_clr, w_err;
  logic              w_bs_next;
  logic [STAT_W-1:0] w_status;
  logic [2:0]        w_idx;
  logic [7:0]        w_ch_pad;

  // One register acts per cycle: EXTEST over SAMPLE_PRELOAD over DEBUG.
  assign w_sel_ext = extest_sel;
  assign w_sel_sp  = !extest_sel && sample_preload_sel;
  assign w_sel_dbg = !extest_sel && !sample_preload_sel && debug_sel;
  assign w_sel_any = extest_sel || sample_preload_sel || debug_sel;

  assign w_cnt_nz = (r_cnt != '0);
  assign w_upd_nz = update_dr_i && w_sel_any && w_cnt_nz;
  assign w_tcr_wr = update_dr_i && w_sel_sp && (r_cnt == TCR_LEN) && r_tcr_shift[CONRLEN-1];
  assign w_trc_wr = update_dr_i && w_sel_ext && (r_cnt == TRC_LEN);
  assign w_clr    = update_dr_i && w_sel_dbg && (r_cnt == DBG_LEN) && r_dbg_shift[0];
  assign w_err    = w_upd_nz && ((w_sel_sp  && (r_cnt != TCR_LEN)) ||
                                 (w_sel_ext && (r_cnt != TRC_LEN)) ||
                                 (w_sel_dbg && (r_cnt != DBG_LEN)));

  assign w_status  = {r_last_cnt, r_err_cnt, r_len_err};
  assign w_bs_next = w_sel_ext ? r_trcal_shift[0] :
                     w_sel_sp  ? r_tcr_shift[0]   : r_dbg_shift[0];

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample the pre-edge values of each other, independent of block order.
  always_ff @(posedge tclk or negedge test_logic_reset_ni) begin
    if (!test_logic_reset_ni) begin
      r_cnt <= '0;
    end else if (w_sel_any) begin
      if (capture_dr_i)                  r_cnt <= '0;
      else if (shift_dr_i && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge tclk or negedge test_logic_reset_ni) begin
    if (!test_logic_reset_ni) begin
      r_tcr_shift   <= '1;
      r_trcal_shift <= '0;
      r_dbg_shift   <= '0;
    end else begin
      if (w_sel_sp) begin
        if (capture_dr_i)    r_tcr_shift <= r_tcr;
        else if (shift_dr_i) r_tcr_shift <= {chiptdi, r_tcr_shift[CONRLEN-1:1]};
      end
      if (w_sel_ext) begin
        if (capture_dr_i)    r_trcal_shift <= trcal_tr_in;
        else if (shift_dr_i) r_trcal_shift <= {chiptdi, r_trcal_shift[TRCAL_SIZE-1:1]};
      end
      if (w_sel_dbg) begin
        if (capture_dr_i)    r_dbg_shift <= w_status;
        else if (shift_dr_i) r_dbg_shift <= {chiptdi, r_dbg_shift[STAT_W-1:1]};
      end
    end
  end

  // The write-key bit is consumed by the update and never stored.
  always_ff @(posedge tclk or negedge test_logic_reset_ni) begin
    if (!test_logic_reset_ni) begin
      r_tcr       <= '0;
      r_trcal_out <= '0;
    end else begin
      if (w_tcr_wr) r_tcr       <= {1'b0, r_tcr_shift[CONRLEN-2:0]};
      if (w_trc_wr) r_trcal_out <= r_trcal_shift;
    end
  end

  always_ff @(posedge tclk or negedge test_logic_reset_ni) begin
    if (!test_logic_reset_ni) begin
      r_last_cnt <= '0;
      r_err_cnt  <= '0;
      r_len_err  <= 1'b0;
    end else begin
      if (w_upd_nz) r_last_cnt <= r_cnt;
      if (w_clr) begin
        r_err_cnt <= '0;
        r_len_err <= 1'b0;
      end else if (w_err) begin
        r_len_err <= 1'b1;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  // Serial out launches on the falling edge, half a cycle after each shift.
  always_ff @(negedge tclk or negedge test_logic_reset_ni) begin
    if (!test_logic_reset_ni) r_bs <= 1'b0;
    else if (w_sel_any)       r_bs <= w_bs_next;
  end

  assign ch_out = ({NUM_CH{r_tcr[CONRLEN-2]}} & r_tcr[NUM_CH-1:0] & ch_in_b) |
                  (~({NUM_CH{r_tcr[CONRLEN-2]}} & r_tcr[NUM_CH-1:0]) & ch_in_a);

  assign w_idx    = r_tcr[NUM_CH+2:NUM_CH];
  assign w_ch_pad = 8'(ch_out);
  assign debug_tdi_o = r_tcr[CONRLEN-2] && r_tcr[CONRLEN-3] &&
                       (4'(w_idx) < 4'(NUM_CH)) && w_ch_pad[w_idx];

  assign tcr_out        = r_tcr;
  assign trcal_tr_out   = r_trcal_out;
  assign len_err_o      = r_len_err;
  assign bs_chain_tdi_o = r_bs;

endmodule

// File: tb/tb_jtag_test_ctrl_bank.sv
// Scoreboard bench for jtag_test_ctrl_bank: expectations are queued when a
// scan is launched and popped as the DUT results become observable.
module tb_jtag_test_ctrl_bank;

  localparam int NUM_CH     = 4;
  localparam int CONRLEN    = 32;
  localparam int TRCAL_SIZE = 32;

  localparam logic [2:0] SEL_EXT = 3'b100;
  localparam logic [2:0] SEL_SP  = 3'b010;
  localparam logic [2:0] SEL_DBG = 3'b001;

  logic                  tclk = 1'b0;
  logic                  test_logic_reset_ni;
  logic                  shift_dr_i, pause_dr_i, update_dr_i, capture_dr_i;
  logic                  sample_preload_sel, extest_sel, debug_sel;
  logic                  chiptdi;
  logic [NUM_CH-1:0]     ch_in_a, ch_in_b, ch_out;
  logic                  debug_tdi_o, bs_chain_tdi_o, len_err_o;
  logic [CONRLEN-1:0]    tcr_out;
  logic [TRCAL_SIZE-1:0] trcal_tr_in, trcal_tr_out;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 tclk = ~tclk;

  jtag_test_ctrl_bank #(
    .NUM_CH    (NUM_CH),
    .CONRLEN   (CONRLEN),
    .TRCAL_SIZE(TRCAL_SIZE)
  ) dut (
    .tclk               (tclk),
    .test_logic_reset_ni(test_logic_reset_ni),
    .shift_dr_i         (shift_dr_i),
    .pause_dr_i         (pause_dr_i),
    .update_dr_i        (update_dr_i),
    .capture_dr_i       (capture_dr_i),
    .sample_preload_sel (sample_preload_sel),
    .extest_sel         (extest_sel),
    .debug_sel          (debug_sel),
    .chiptdi            (chiptdi),
    .ch_in_a            (ch_in_a),
    .ch_in_b            (ch_in_b),
    .ch_out             (ch_out),
    .debug_tdi_o        (debug_tdi_o),
    .bs_chain_tdi_o     (bs_chain_tdi_o),
    .tcr_out            (tcr_out),
    .trcal_tr_in        (trcal_tr_in),
    .trcal_tr_out       (trcal_tr_out),
    .len_err_o          (len_err_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic compare_next(input logic [63:0] act);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underflow: got 0x%0h expected nothing", act);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, act, e.val);
    end
  endtask

  // Reference mux: channel i takes b only when global enable and its select are set.
  function automatic logic [3:0] mux_model(input logic [31:0] tcr, input logic [3:0] a,
                                           input logic [3:0] b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (tcr[30] && tcr[i]) ? b[i] : a[i];
    return r;
  endfunction

  // Full capture/shift/update scan; dout collects bs_chain_tdi_o LSB-first.
  task automatic scan(input logic [2:0] sel, input int nbits, input logic [63:0] din,
                      input int pause_at, output logic [63:0] dout);
    dout = '0;
    {extest_sel, sample_preload_sel, debug_sel} = sel;
    capture_dr_i = 1'b1;
    @(posedge tclk); #1;
    capture_dr_i = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == pause_at) begin
        shift_dr_i = 1'b0;
        pause_dr_i = 1'b1;
        repeat (2) begin @(posedge tclk); #1; end
        pause_dr_i = 1'b0;
      end
      shift_dr_i = 1'b1;
      chiptdi    = din[i];
      @(negedge tclk); #1;
      dout[i] = bs_chain_tdi_o;
      @(posedge tclk); #1;
    end
    shift_dr_i  = 1'b0;
    update_dr_i = 1'b1;
    @(posedge tclk); #1;
    update_dr_i = 1'b0;
    {extest_sel, sample_preload_sel, debug_sel} = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    logic [63:0] dout;
    test_logic_reset_ni = 1'b0;
    {shift_dr_i, pause_dr_i, update_dr_i, capture_dr_i} = 4'b0000;
    {extest_sel, sample_preload_sel, debug_sel} = 3'b000;
    chiptdi     = 1'b0;
    ch_in_a     = 4'b0110;
    ch_in_b     = 4'b1001;
    trcal_tr_in = 32'hA5A5_5A5A;

    #12;
    check("rst_tcr_out", tcr_out, 0);
    check("rst_trcal_out", trcal_tr_out, 0);
    check("rst_len_err", len_err_o, 0);
    check("rst_bs", bs_chain_tdi_o, 0);
    check("rst_debug", debug_tdi_o, 0);
    check("rst_ch_out", ch_out, 4'b0110);
    @(posedge tclk); #1;
    test_logic_reset_ni = 1'b1;
    @(posedge tclk); #1;

    // Keyed TCR write: key bit dropped, channels 0/1 switch to b.
    expect_val("sp_wr_dout", 64'h0);
    expect_val("sp_wr_tcr", 32'h4000_0003);
    expect_val("sp_wr_ch_out", 4'b0101);
    expect_val("sp_wr_len_err", 0);
    scan(SEL_SP, 32, 64'hC000_0003, -1, dout);
    compare_next(dout);
    compare_next(tcr_out);
    compare_next(ch_out);
    compare_next(len_err_o);

    // Read-back split by pause, key clear: TCR must not change.
    expect_val("sp_rd_dout", 64'h4000_0003);
    expect_val("sp_rd_tcr", 32'h4000_0003);
    expect_val("sp_rd_len_err", 0);
    scan(SEL_SP, 32, 64'h0, 10, dout);
    compare_next(dout);
    compare_next(tcr_out);
    compare_next(len_err_o);

    // Short scan with key set is rejected and flagged.
    expect_val("sp31_tcr", 32'h4000_0003);
    expect_val("sp31_len_err", 1);
    scan(SEL_SP, 31, 64'hFFFF_FFFF, -1, dout);
    compare_next(tcr_out);
    compare_next(len_err_o);

    expect_val("dbg_rd1", {8'd31, 7'd1, 1'b1});
    scan(SEL_DBG, 16, 64'h0, -1, dout);
    compare_next(dout);

    expect_val("dbg_clr_dout", {8'd16, 7'd1, 1'b1});
    expect_val("dbg_clr_len_err", 0);
    scan(SEL_DBG, 16, 64'h1, -1, dout);
    compare_next(dout);
    compare_next(len_err_o);

    expect_val("zero_len_err", 0);
    expect_val("zero_tcr", 32'h4000_0003);
    scan(SEL_SP, 0, 64'h0, -1, dout);
    compare_next(len_err_o);
    compare_next(tcr_out);

    expect_val("dbg_rd2", {8'd16, 7'd0, 1'b0});
    scan(SEL_DBG, 16, 64'h0, -1, dout);
    compare_next(dout);

    // EXTEST capture/shift/update and a wrong-length update.
    expect_val("ext_dout", 64'hA5A5_5A5A);
    expect_val("ext_out", 32'h1234_5678);
    expect_val("ext_len_err", 0);
    scan(SEL_EXT, 32, 64'h1234_5678, -1, dout);
    compare_next(dout);
    compare_next(trcal_tr_out);
    compare_next(len_err_o);

    expect_val("ext5_dout", 64'h1A);
    expect_val("ext5_out", 32'h1234_5678);
    expect_val("ext5_len_err", 1);
    scan(SEL_EXT, 5, 64'h1F, -1, dout);
    compare_next(dout);
    compare_next(trcal_tr_out);
    compare_next(len_err_o);

    // EXTEST wins over SAMPLE_PRELOAD when both are selected.
    expect_val("prio_dout", 64'hA5A5_5A5A);
    expect_val("prio_ext_out", 32'hFFFF_FFFF);
    expect_val("prio_tcr", 32'h4000_0003);
    scan(SEL_EXT | SEL_SP, 32, 64'hFFFF_FFFF, -1, dout);
    compare_next(dout);
    compare_next(trcal_tr_out);
    compare_next(tcr_out);

    // Observe channel 2.
    expect_val("obs_tcr", 32'h6000_0025);
    expect_val("obs_ch_out", mux_model(32'h6000_0025, 4'b0110, 4'b1001));
    expect_val("obs_dbg_b0", 0);
    scan(SEL_SP, 32, 64'hE000_0025, -1, dout);
    compare_next(tcr_out);
    compare_next(ch_out);
    compare_next(debug_tdi_o);
    ch_in_b = 4'b0100;
    expect_val("obs_ch_out_b4", mux_model(32'h6000_0025, 4'b0110, 4'b0100));
    expect_val("obs_dbg_b4", 1);
    #1;
    compare_next(ch_out);
    compare_next(debug_tdi_o);
    ch_in_b = 4'b1001;
    expect_val("obs_dbg_b9", 0);
    #1;
    compare_next(debug_tdi_o);

    // Out-of-range observe index.
    ch_in_a = 4'b1111;
    ch_in_b = 4'b1111;
    expect_val("obs5_tcr", 32'h6000_0055);
    expect_val("obs5_dbg", 0);
    scan(SEL_SP, 32, 64'hE000_0055, -1, dout);
    compare_next(tcr_out);
    compare_next(debug_tdi_o);

    // Error counter saturation.
    for (int n = 0; n < 130; n++) scan(SEL_SP, 1, 64'h0, -1, dout);
    expect_val("sat_len_err", 1);
    expect_val("sat_status", {8'd1, 7'd127, 1'b1});
    compare_next(len_err_o);
    scan(SEL_DBG, 16, 64'h0, -1, dout);
    compare_next(dout);

    // Asynchronous reset in the middle of a shift.
    ch_in_a = 4'b1010;
    ch_in_b = 4'b0101;
    {extest_sel, sample_preload_sel, debug_sel} = SEL_SP;
    capture_dr_i = 1'b1;
    @(posedge tclk); #1;
    capture_dr_i = 1'b0;
    shift_dr_i   = 1'b1;
    chiptdi      = 1'b1;
    repeat (5) begin @(posedge tclk); #1; end
    @(negedge tclk); #2;
    test_logic_reset_ni = 1'b0;
    #1;
    check("mid_rst_tcr_out", tcr_out, 0);
    check("mid_rst_trcal_out", trcal_tr_out, 0);
    check("mid_rst_len_err", len_err_o, 0);
    check("mid_rst_bs", bs_chain_tdi_o, 0);
    check("mid_rst_debug", debug_tdi_o, 0);
    check("mid_rst_ch_out", ch_out, 4'b1010);
    shift_dr_i = 1'b0;
    {extest_sel, sample_preload_sel, debug_sel} = 3'b000;
    @(posedge tclk); #1;
    test_logic_reset_ni = 1'b1;
    @(posedge tclk); #1;

    // TCR shift register comes out of reset all ones.
    sample_preload_sel = 1'b1;
    @(negedge tclk); #1;
    check("rst_tcr_shift_bit0", bs_chain_tdi_o, 1);
    @(posedge tclk); #1;
    sample_preload_sel = 1'b0;

    expect_val("post_rst_dout", 64'h0);
    expect_val("post_rst_tcr", 32'h0);
    scan(SEL_SP, 32, 64'h0, -1, dout);
    compare_next(dout);
    compare_next(tcr_out);
    expect_val("post_rst_status", {8'd32, 7'd0, 1'b0});
    scan(SEL_DBG, 16, 64'h0, -1, dout);
    compare_next(dout);

    check("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
